// File: rtl/aes_keyslot_pkg.sv
// Shared types and register map constants for the AES key-slot front end.
// FSM states, word indices, CTRL bit positions and lock bit indices.
package aes_keyslot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [6:0] IDX_CTRL   = 7'd0;
  localparam logic [6:0] IDX_PT     = 7'd1;
  localparam logic [6:0] IDX_STATE  = 7'd5;
  localparam logic [6:0] IDX_RESULT = 7'd9;
  localparam logic [6:0] IDX_GAP    = 7'd13;
  localparam logic [6:0] IDX_KEY    = 7'd16;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ZERO    = 1;
  localparam int CTRL_KSEL_LO = 4;

  localparam int LK_CTRL_RD = 0;
  localparam int LK_CTRL_WR = 1;
  localparam int LK_BLK_RD  = 2;
  localparam int LK_BLK_WR  = 3;
  localparam int LK_RES_RD  = 4;
  localparam int LK_KEY_WR  = 5;
  localparam int LK_ZERO    = 7;

endpackage

// File: rtl/aes_keyslot_bank.sv
// Write-only key slot storage with per-word writes, one-cycle zeroize
// and a selected-slot read port feeding the core.
module aes_keyslot_bank
  import aes_keyslot_pkg::*;
#(
  parameter int NUM_KEYS   = 4,
  parameter int KEY_WIDTH  = 192,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we,
  input  logic [2:0]            slot,
  input  logic [2:0]            word,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  zeroize,
  input  logic [2:0]            sel,
  output logic [KEY_WIDTH-1:0]  key
);

  localparam int KW = KEY_WIDTH / DATA_WIDTH;

  logic [KW-1:0][DATA_WIDTH-1:0] mem [NUM_KEYS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NUM_KEYS; s++) mem[s] <= '0;
    end else if (zeroize) begin
      for (int s = 0; s < NUM_KEYS; s++) mem[s] <= '0;
    end else if (we) begin
      for (int s = 0; s < NUM_KEYS; s++)
        for (int w = 0; w < KW; w++)
          if (slot == 3'(s) && word == 3'(w))
            mem[s][w] <= wdata;
    end
  end

  always_comb begin
    key = '0;
    for (int s = 0; s < NUM_KEYS; s++)
      if (sel == 3'(s)) key = mem[s];
  end

endmodule

// File: rtl/aes_keyslot_wrapper.sv
// Register-bus front end for an AES-192 core: key slots, start/busy/done
// FSM with timeout, result capture, zeroize and access error reporting.
module aes_keyslot_wrapper
  import aes_keyslot_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_KEYS       = 4,
  parameter int KEY_WIDTH      = 192,
  parameter int BLK_WIDTH      = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [7:0]            reglk_ctrl_i,
  input  logic [ADDR_WIDTH-1:0] reg_addr_i,
  input  logic                  reg_write_i,
  input  logic                  reg_valid_i,
  input  logic [DATA_WIDTH-1:0] reg_wdata_i,
  output logic [DATA_WIDTH-1:0] reg_rdata_o,
  output logic                  reg_ready_o,
  output logic                  reg_error_o,
  output logic                  core_start_o,
  output logic [KEY_WIDTH-1:0]  core_key_o,
  output logic [BLK_WIDTH-1:0]  core_state_o,
  output logic [BLK_WIDTH-1:0]  core_pt_o,
  input  logic [BLK_WIDTH-1:0]  core_out_i,
  input  logic                  core_valid_i
);

  localparam int KW = KEY_WIDTH / DATA_WIDTH;
  localparam int BW = BLK_WIDTH / DATA_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] NK = 4'(NUM_KEYS);
  localparam logic [3:0] NW = 4'(KW);

  state_e state, state_n;
  logic [BW-1:0][DATA_WIDTH-1:0] pt_q, st_q, res_q;
  logic [2:0] key_sel;
  logic [CW-1:0] cnt;
  logic done, err, start_q, busy;

  logic [6:0] idx, koff;
  logic [2:0] kslot, kword, ksel_new;
  logic [1:0] psub, ssub, rsub;
  logic is_ctrl, is_pt, is_st, is_res, is_key, mapped;
  logic ksel_chg, ctrl_bad, wr_bad, ok_wr, rd;
  logic key_we, zero_req, start_req;
  logic launch, capture, expire;
  logic unused;

  assign unused = ^{reg_addr_i[ADDR_WIDTH-1:9],
                    reg_addr_i[1:0], reglk_ctrl_i[6]};

  assign idx   = reg_addr_i[8:2];
  assign koff  = idx - IDX_KEY;
  assign kslot = koff[5:3];
  assign kword = koff[2:0];
  assign psub  = 2'(idx - IDX_PT);
  assign ssub  = 2'(idx - IDX_STATE);
  assign rsub  = 2'(idx - IDX_RESULT);

  assign is_ctrl = idx == IDX_CTRL;
  assign is_pt   = idx >= IDX_PT && idx < IDX_STATE;
  assign is_st   = idx >= IDX_STATE && idx < IDX_RESULT;
  assign is_res  = idx >= IDX_RESULT && idx < IDX_GAP;
  assign is_key  = idx >= IDX_KEY && !koff[6] &&
                   ({1'b0, kslot} < NK) && ({1'b0, kword} < NW);
  assign mapped  = is_ctrl | is_pt | is_st | is_res | is_key;

  assign busy = state == ST_RUN;
  assign rd   = reg_valid_i & ~reg_write_i;

  // KEY_SEL counts as written only when the value actually changes,
  // so START can be re-issued with the current selection while busy.
  assign ksel_new = reg_wdata_i[CTRL_KSEL_LO +: 3];
  assign ksel_chg = ksel_new != key_sel;
  assign ctrl_bad = reglk_ctrl_i[LK_CTRL_WR]
                  | ({1'b0, ksel_new} >= NK)
                  | (ksel_chg & (reglk_ctrl_i[LK_KEY_WR] | busy))
                  | (reg_wdata_i[CTRL_ZERO] & reglk_ctrl_i[LK_ZERO]);
  assign wr_bad = (is_ctrl & ctrl_bad)
                | ((is_pt | is_st) & (reglk_ctrl_i[LK_BLK_WR] | busy))
                | (is_key & (reglk_ctrl_i[LK_KEY_WR] | busy))
                | is_res;

  assign reg_error_o = reg_valid_i & (~mapped | (reg_write_i & wr_bad));
  assign ok_wr = reg_valid_i & reg_write_i & mapped & ~wr_bad;

  assign key_we    = ok_wr & is_key;
  assign zero_req  = ok_wr & is_ctrl & reg_wdata_i[CTRL_ZERO];
  assign start_req = ok_wr & is_ctrl & reg_wdata_i[CTRL_START]
                   & ~reg_wdata_i[CTRL_ZERO];

  always_comb begin
    reg_rdata_o = '0;
    if (rd) begin
      if (is_ctrl && !reglk_ctrl_i[LK_CTRL_RD])
        reg_rdata_o = DATA_WIDTH'({key_sel, 1'b0, err, done, busy});
      else if (is_pt && !reglk_ctrl_i[LK_BLK_RD])
        reg_rdata_o = pt_q[psub];
      else if (is_st && !reglk_ctrl_i[LK_BLK_RD])
        reg_rdata_o = st_q[ssub];
      else if (is_res && !reglk_ctrl_i[LK_RES_RD])
        reg_rdata_o = res_q[rsub];
    end
  end

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start_req) begin
          state_n = ST_RUN;
          launch  = 1'b1;
        end
      end
      ST_RUN: begin
        if (core_valid_i) begin
          state_n = ST_DONE;
          capture = 1'b1;
        end else if (cnt == TMAX) begin
          state_n = ST_DONE;
          expire  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (zero_req) state_n = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pt_q    <= '0;
      st_q    <= '0;
      res_q   <= '0;
      key_sel <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      start_q <= 1'b0;
    end else if (zero_req) begin
      pt_q    <= '0;
      st_q    <= '0;
      res_q   <= '0;
      key_sel <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= launch;
      if (launch) begin
        done <= 1'b0;
        err  <= 1'b0;
        cnt  <= '0;
      end else if (busy) begin
        cnt <= cnt + CW'(1);
      end
      if (capture) begin
        res_q <= core_out_i;
        done  <= 1'b1;
      end
      if (expire) begin
        done <= 1'b1;
        err  <= 1'b1;
      end
      if (ok_wr && is_pt)   pt_q[psub] <= reg_wdata_i;
      if (ok_wr && is_st)   st_q[ssub] <= reg_wdata_i;
      if (ok_wr && is_ctrl) key_sel    <= ksel_new;
    end
  end

  aes_keyslot_bank #(
    .NUM_KEYS   (NUM_KEYS),
    .KEY_WIDTH  (KEY_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we      (key_we),
    .slot    (kslot),
    .word    (kword),
    .wdata   (reg_wdata_i),
    .zeroize (zero_req),
    .sel     (key_sel),
    .key     (core_key_o)
  );

  assign reg_ready_o  = 1'b1;
  assign core_start_o = start_q;
  assign core_pt_o    = pt_q;
  assign core_state_o = st_q;

endmodule
